// File: rtl/ysyx_22041752_sram_arb.sv
// ysyx_22041752_sram_arb: arbitrates an inst and a data requester onto one SRAM-like port,
// one outstanding transaction at a time, alternating on ties; outputs are held low during reset.
module ysyx_22041752_sram_arb #(
    parameter int ADDR_WD = 64,
    parameter int DATA_WD = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inst_req,
    input  logic [ADDR_WD-1:0]   inst_addr,
    output logic                 inst_addr_ok,
    output logic                 inst_data_ok,
    output logic [DATA_WD-1:0]   inst_rdata,
    input  logic                 data_req,
    input  logic                 data_wr,
    input  logic [1:0]           data_size,
    input  logic [DATA_WD/8-1:0] data_wstrb,
    input  logic [ADDR_WD-1:0]   data_addr,
    input  logic [DATA_WD-1:0]   data_wdata,
    output logic                 data_addr_ok,
    output logic                 data_data_ok,
    output logic [DATA_WD-1:0]   data_rdata,
    output logic                 mem_req,
    output logic                 mem_wr,
    output logic [1:0]           mem_size,
    output logic [DATA_WD/8-1:0] mem_wstrb,
    output logic [ADDR_WD-1:0]   mem_addr,
    output logic [DATA_WD-1:0]   mem_wdata,
    input  logic                 mem_addr_ok,
    input  logic                 mem_data_ok,
    input  logic [DATA_WD-1:0]   mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                 r_state, w_next;
    logic                   r_owner, r_last, r_wr;
    logic [1:0]             r_size;
    logic [DATA_WD/8-1:0]   r_wstrb;
    logic [ADDR_WD-1:0]     r_addr;
    logic [DATA_WD-1:0]     r_wdata;
    logic                   w_gnt_data, w_gnt_inst, w_acc, w_in_req, w_done;

    // r_owner/r_last: 1 = data requester; data wins a tie unless it won the previous grant
    assign w_gnt_data = data_req & (~inst_req | ~r_last);
    assign w_gnt_inst = inst_req & ~w_gnt_data;
    assign w_acc      = reset & (r_state == IDLE) & (inst_req | data_req);
    assign w_in_req   = reset & (r_state == REQ);
    assign w_done     = reset & (r_state == RESP) & mem_data_ok;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (inst_req | data_req) ? REQ : IDLE;
            REQ:     w_next = mem_addr_ok ? RESP : REQ;
            RESP:    w_next = mem_data_ok ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= '0;
            r_wstrb <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_owner <= w_gnt_data;
                r_last  <= w_gnt_data;
                r_wr    <= w_gnt_data & data_wr;
                r_size  <= w_gnt_data ? data_size : 2'b11;
                r_wstrb <= w_gnt_data ? data_wstrb : '0;
                r_addr  <= w_gnt_data ? data_addr : inst_addr;
                r_wdata <= w_gnt_data ? data_wdata : '0;
            end
        end
    end

    assign inst_addr_ok = w_acc & w_gnt_inst;
    assign data_addr_ok = w_acc & w_gnt_data;
    assign mem_req      = w_in_req;
    assign mem_wr       = w_in_req & r_wr;
    assign mem_size     = w_in_req ? r_size : '0;
    assign mem_wstrb    = w_in_req ? r_wstrb : '0;
    assign mem_addr     = w_in_req ? r_addr : '0;
    assign mem_wdata    = w_in_req ? r_wdata : '0;
    assign inst_data_ok = w_done & ~r_owner;
    assign data_data_ok = w_done & r_owner;
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = (data_data_ok & ~r_wr) ? mem_rdata : '0;
endmodule

// File: doc/ysyx_22041752_sram_arb.md
YSYX_22041752_SRAM_ARB -- requirements
Module: ysyx_22041752_sram_arb

Interface
REQ-001 Parameter ADDR_WD, default 64, width of every address port.
REQ-002 Parameter DATA_WD, default 64, width of every data port; the wstrb width SHALL be DATA_WD/8.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: the reset is synchronous and active-low.
REQ-005 Inst requester ports:
- inst_req, in, 1: read request.
- inst_addr, in, ADDR_WD: read address.
- inst_addr_ok, out, 1: request accepted.
- inst_data_ok, out, 1: read data valid.
- inst_rdata, out, DATA_WD: read data.
REQ-006 Data requester ports:
- data_req, in, 1: request.
- data_wr, in, 1: 1 = write.
- data_size, in, 2: 00/01/10/11 = 1/2/4/8 bytes.
- data_wstrb, in, DATA_WD/8: byte enables.
- data_addr, in, ADDR_WD: address.
- data_wdata, in, DATA_WD: write data.
- data_addr_ok, out, 1: request accepted.
- data_data_ok, out, 1: read data valid or write acknowledged.
- data_rdata, out, DATA_WD: read data.
REQ-007 Shared memory port outputs:
- mem_req, out, 1: request.
- mem_wr, out, 1: 1 = write.
- mem_size, out, 2: transfer size.
- mem_wstrb, out, DATA_WD/8: byte enables.
- mem_addr, out, ADDR_WD: address.
- mem_wdata, out, DATA_WD: write data.
REQ-008 Shared memory port inputs:
- mem_addr_ok, in, 1: memory accepted the request.
- mem_data_ok, in, 1: response valid.
- mem_rdata, in, DATA_WD: read data.

Function
REQ-009 The block SHALL be a 3-state FSM with states IDLE, REQ and RESP, and SHALL allow at most one outstanding memory transaction.
REQ-010 IDLE behaviour:
- If any of inst_req or data_req is high, the block SHALL grant one requester combinationally and assert that requester's addr_ok in the same cycle.
- The block SHALL latch the owner and the request fields, then go to REQ.
- For an inst grant, the latched fields SHALL be mem_wr=0, mem_size=2'b11, mem_wstrb=0 and mem_wdata=0.
REQ-011 Arbitration SHALL follow these rules:
- If only one requester is active, that requester SHALL be granted.
- If both are active, the requester not granted last SHALL win.
- last_owner SHALL reset to inst, so data wins the first tie.
REQ-012 In REQ, mem_req SHALL be 1 and all mem_* fields SHALL be driven from registers; on mem_addr_ok=1 the block SHALL go to RESP.
REQ-013 In RESP, mem_req SHALL be 0; on mem_data_ok=1 the block SHALL pulse the owner's data_ok for exactly that cycle with rdata=mem_rdata passed combinationally, then go to IDLE.
REQ-014 Latencies SHALL be:
- addr_ok to mem_req: 1 cycle.
- mem_data_ok to owner data_ok: 0 cycles.
- Minimum transaction: 3 cycles.
- Back-to-back throughput: 1 transaction per 3 cycles.
REQ-015 No addr_ok SHALL be asserted in REQ or RESP, including the RESP cycle that completes; a new accept SHALL occur no earlier than the next IDLE cycle.
REQ-016 Mutual exclusion and quiet outputs:
- inst_addr_ok and data_addr_ok SHALL never both be 1.
- inst_data_ok and data_data_ok SHALL never both be 1.
- The non-owner's rdata SHALL be 0.
REQ-017 mem_addr_ok SHALL be ignored outside REQ, and mem_data_ok SHALL be ignored outside RESP, including when both are asserted in the same REQ cycle.
REQ-018 Requesters hold req and fields until addr_ok; the block SHALL sample the fields only in the accepting cycle.
REQ-019 Writes SHALL complete through the same REQ/RESP path; the data_data_ok of a write SHALL carry data_rdata=0.

Reset
REQ-020 While reset=0 at a rising clk edge, the block SHALL set state=IDLE, last_owner=inst and all latched fields=0.
REQ-021 While reset=0, all outputs SHALL be 0, and no addr_ok SHALL be issued in a cycle where reset=0.
REQ-022 A reset asserted in REQ or RESP SHALL abort the transaction with no data_ok; a mem_data_ok arriving after reset release SHALL be ignored by REQ-017.

Verification
REQ-023 Scenario: inst_req=1, inst_addr=0x80000000; memory gives addr_ok 1 cycle after mem_req and data_ok 2 cycles later with rdata=0x00000013 -> inst_addr_ok in cycle 0, mem_req in cycle 1, inst_data_ok=1 and inst_rdata=0x13 in cycle 4.
REQ-024 Scenario: inst_req and data_req both held high for 4 transactions -> grant order data, inst, data, inst, and never two addr_ok in one cycle.
REQ-025 Scenario: data write with addr=0x80001000, wdata=0xDEADBEEF, wstrb=8'h0F, size=10 -> mem_wr=1, mem_wstrb=0x0F and mem_size=10 while mem_req=1; data_data_ok=1 with data_rdata=0.
REQ-026 Scenario: mem_addr_ok held low 5 cycles in REQ -> mem_req stays 1 with stable fields, and no new addr_ok is issued.
REQ-027 Scenario: reset=0 asserted in RESP, then mem_data_ok=1 after release -> no data_ok pulse; state=IDLE; the next inst_req is accepted normally.
REQ-028 Scenario: mem_data_ok=1 in IDLE or REQ -> no data_ok output and no state change.
